// File: rtl/utils_pkg.sv
// Shared AXI4 types for the nox core ports and the memory responders on the other end.
package utils_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_ID_W   = 8;

  typedef logic [AXI_ADDR_W-1:0]   axi_addr_t;
  typedef logic [AXI_DATA_W-1:0]   axi_data_t;
  typedef logic [AXI_DATA_W/8-1:0] axi_strb_t;
  typedef logic [AXI_ID_W-1:0]     axi_id_t;

  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} axi_burst_t;
  typedef enum logic [1:0] {OKAY, EXOKAY, SLVERR, DECERR} axi_resp_t;
  typedef enum logic [2:0] {
    SIZE_1B, SIZE_2B, SIZE_4B, SIZE_8B, SIZE_16B, SIZE_32B, SIZE_64B, SIZE_128B
  } axi_size_t;

  typedef struct packed {
    axi_id_t    awid;
    axi_addr_t  awaddr;
    logic [7:0] awlen;
    axi_size_t  awsize;
    axi_burst_t awburst;
    logic       awvalid;
    axi_data_t  wdata;
    axi_strb_t  wstrb;
    logic       wlast;
    logic       wvalid;
    logic       bready;
    axi_id_t    arid;
    axi_addr_t  araddr;
    logic [7:0] arlen;
    axi_size_t  arsize;
    axi_burst_t arburst;
    logic       arvalid;
    logic       rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic      awready;
    logic      wready;
    axi_id_t   bid;
    axi_resp_t bresp;
    logic      bvalid;
    logic      arready;
    axi_id_t   rid;
    axi_data_t rdata;
    axi_resp_t rresp;
    logic      rlast;
    logic      rvalid;
  } s_axi_miso_t;

  function automatic logic addr_in_range(input axi_addr_t addr, input axi_addr_t base,
                                         input axi_addr_t bytes);
    return (addr - base) < bytes;
  endfunction

  // WRAP bursts are flagged as errors elsewhere, so only INCR moves the address.
  function automatic axi_addr_t next_beat_addr(input axi_addr_t addr, input axi_size_t size,
                                               input axi_burst_t burst);
    return (burst == INCR) ? addr + (axi_addr_t'(1) << size) : addr;
  endfunction

endpackage

// File: rtl/nox_mem_array.sv
// 1R1W byte-strobed synchronous-read RAM; no reset so it maps onto block RAM.
module nox_mem_array #(
  parameter int unsigned DEPTH = 8192
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // Same-address read and write in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/nox_axi_mem.sv
// AXI4 slave SRAM with independent read/write engines, one outstanding burst per direction.
module nox_axi_mem
  import utils_pkg::*;
#(
  parameter int unsigned MEM_KB    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        arst,
  input  s_axi_mosi_t axi_mosi_i,
  output s_axi_miso_t axi_miso_o
);

  localparam int unsigned DEPTH     = MEM_KB * 256;
  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam axi_addr_t   MEM_BYTES = axi_addr_t'(MEM_KB * 1024);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic [IDX_W-1:0] word_idx(input axi_addr_t a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic beat_bad(input axi_addr_t a, input axi_size_t s, input axi_burst_t b);
    return (s > SIZE_4B) || !(b == FIXED || b == INCR) || !addr_in_range(a, BASE_ADDR, MEM_BYTES);
  endfunction

  w_state_t   w_state;
  logic       awready_q, wready_q, bvalid_q, w_err;
  axi_resp_t  bresp_q;
  axi_id_t    bid_q;
  axi_addr_t  w_addr;
  logic [7:0] w_len, w_beat;
  axi_size_t  w_size;
  axi_burst_t w_burst;

  r_state_t   r_state;
  logic       arready_q, rvalid_q, rlast_q;
  axi_resp_t  rresp_q;
  axi_id_t    rid_q;
  axi_addr_t  r_addr, r_next;
  logic [7:0] r_len, r_beat;
  axi_size_t  r_size;
  axi_burst_t r_burst;

  logic             w_last_beat, w_beat_err, mem_we, mem_re, ar_hs, r_hs;
  logic [IDX_W-1:0] mem_raddr;
  logic [31:0]      mem_rdata;

  assign w_last_beat = (w_beat == w_len);
  assign w_beat_err  = beat_bad(w_addr, w_size, w_burst) || (axi_mosi_i.wlast != w_last_beat);
  assign mem_we      = wready_q && axi_mosi_i.wvalid && !w_err && !w_beat_err;

  // The RAM is read on the handshake edge so the next beat is ready one cycle later.
  assign ar_hs     = arready_q && axi_mosi_i.arvalid;
  assign r_hs      = rvalid_q && axi_mosi_i.rready;
  assign r_next    = next_beat_addr(r_addr, r_size, r_burst);
  assign mem_re    = ar_hs || (r_hs && !rlast_q);
  assign mem_raddr = ar_hs ? word_idx(axi_mosi_i.araddr) : word_idx(r_next);

  nox_mem_array #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (word_idx(w_addr)),
    .wdata (axi_mosi_i.wdata),
    .wstrb (axi_mosi_i.wstrb),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      bid_q     <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_beat    <= '0;
      w_size    <= SIZE_1B;
      w_burst   <= FIXED;
      w_err     <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (axi_mosi_i.awvalid) begin
          bid_q     <= axi_mosi_i.awid;
          w_addr    <= axi_mosi_i.awaddr;
          w_len     <= axi_mosi_i.awlen;
          w_size    <= axi_mosi_i.awsize;
          w_burst   <= axi_mosi_i.awburst;
          w_beat    <= '0;
          w_err     <= 1'b0;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          w_state   <= W_DATA;
        end
        W_DATA: if (axi_mosi_i.wvalid) begin
          w_addr <= next_beat_addr(w_addr, w_size, w_burst);
          w_beat <= w_beat + 8'd1;
          w_err  <= w_err || w_beat_err;
          if (w_last_beat) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= (w_err || w_beat_err) ? SLVERR : OKAY;
            w_state  <= W_RESP;
          end
        end
        W_RESP: if (axi_mosi_i.bready) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          w_state   <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= OKAY;
      rid_q     <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_size    <= SIZE_1B;
      r_burst   <= FIXED;
    end else begin
      case (r_state)
        R_IDLE: if (axi_mosi_i.arvalid) begin
          rid_q     <= axi_mosi_i.arid;
          r_addr    <= axi_mosi_i.araddr;
          r_len     <= axi_mosi_i.arlen;
          r_size    <= axi_mosi_i.arsize;
          r_burst   <= axi_mosi_i.arburst;
          r_beat    <= '0;
          rvalid_q  <= 1'b1;
          rlast_q   <= (axi_mosi_i.arlen == 8'd0);
          rresp_q   <= beat_bad(axi_mosi_i.araddr, axi_mosi_i.arsize, axi_mosi_i.arburst)
                       ? SLVERR : OKAY;
          arready_q <= 1'b0;
          r_state   <= R_DATA;
        end
        R_DATA: if (axi_mosi_i.rready) begin
          if (rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            r_state   <= R_IDLE;
          end else begin
            r_addr  <= r_next;
            r_beat  <= r_beat + 8'd1;
            rlast_q <= ((r_beat + 8'd1) == r_len);
            rresp_q <= beat_bad(r_next, r_size, r_burst) ? SLVERR : OKAY;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Error beats and idle cycles present zero instead of the raw RAM output.
  always_comb begin
    axi_miso_o         = '0;
    axi_miso_o.awready = awready_q;
    axi_miso_o.wready  = wready_q;
    axi_miso_o.bvalid  = bvalid_q;
    axi_miso_o.bresp   = bresp_q;
    axi_miso_o.bid     = bid_q;
    axi_miso_o.arready = arready_q;
    axi_miso_o.rvalid  = rvalid_q;
    axi_miso_o.rresp   = rresp_q;
    axi_miso_o.rlast   = rlast_q;
    axi_miso_o.rid     = rid_q;
    axi_miso_o.rdata   = (rvalid_q && rresp_q == OKAY) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_nox_axi_mem.sv
// Directed bench for nox_axi_mem: writes, bursts, strobes, error responses, concurrency, reset.
module tb_nox_axi_mem;
  import utils_pkg::*;

  localparam int MAXW = 50;

  logic        clk;
  logic        arst;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;

  int total = 0;
  int bad   = 0;

  logic [31:0] wd [8];
  logic [3:0]  ws [8];
  logic        wl [8];
  axi_resp_t   bresp_c;
  axi_id_t     bid_c;

  logic [31:0] rd [8];
  axi_resp_t   rr [8];
  logic        rl [8];
  axi_id_t     rid_c;
  logic        first_rv, stall_v;
  logic [31:0] stall_d0, stall_d1;

  nox_axi_mem #(.MEM_KB(32), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .arst       (arst),
    .axi_mosi_i (mosi),
    .axi_miso_o (miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string what);
    total++;
    bad++;
    $display("FAIL timeout_%s got=no_handshake exp=handshake", what);
  endtask

  task automatic do_write(input logic [31:0] addr, input axi_id_t id, input logic [7:0] len,
                          input axi_size_t size, input axi_burst_t burst);
    int n;
    mosi.awvalid = 1'b1; mosi.awaddr = addr; mosi.awid = id;
    mosi.awlen = len; mosi.awsize = size; mosi.awburst = burst;
    n = 0;
    while (!miso.awready && n < MAXW) begin step(); n++; end
    if (n == MAXW) timeout("aw");
    step();
    mosi.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      mosi.wvalid = 1'b1; mosi.wdata = wd[i]; mosi.wstrb = ws[i]; mosi.wlast = wl[i];
      n = 0;
      while (!miso.wready && n < MAXW) begin step(); n++; end
      if (n == MAXW) timeout("w");
      step();
    end
    mosi.wvalid = 1'b0; mosi.wlast = 1'b0;
    mosi.bready = 1'b1;
    n = 0;
    while (!miso.bvalid && n < MAXW) begin step(); n++; end
    if (n == MAXW) timeout("b");
    bresp_c = miso.bresp;
    bid_c   = miso.bid;
    step();
    mosi.bready = 1'b0;
  endtask

  task automatic wr1(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    wd[0] = data; ws[0] = strb; wl[0] = 1'b1;
    do_write(addr, '0, 8'd0, SIZE_4B, INCR);
  endtask

  task automatic do_read(input logic [31:0] addr, input axi_id_t id, input logic [7:0] len,
                         input axi_size_t size, input axi_burst_t burst, input int stall_idx);
    int n;
    mosi.arvalid = 1'b1; mosi.araddr = addr; mosi.arid = id;
    mosi.arlen = len; mosi.arsize = size; mosi.arburst = burst;
    n = 0;
    while (!miso.arready && n < MAXW) begin step(); n++; end
    if (n == MAXW) timeout("ar");
    step();
    mosi.arvalid = 1'b0;
    first_rv = miso.rvalid;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_idx) begin
        mosi.rready = 1'b0;
        stall_d0 = miso.rdata;
        step();
        stall_d1 = miso.rdata;
        stall_v  = miso.rvalid;
        step();
      end
      mosi.rready = 1'b1;
      n = 0;
      while (!miso.rvalid && n < MAXW) begin step(); n++; end
      if (n == MAXW) timeout("r");
      rd[i] = miso.rdata; rr[i] = miso.rresp; rl[i] = miso.rlast; rid_c = miso.rid;
      step();
    end
    mosi.rready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({miso.awready, miso.arready, miso.wready, miso.bvalid, miso.rvalid, miso.rlast} !== 6'b110000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=110000",
               {miso.awready, miso.arready, miso.wready, miso.bvalid, miso.rvalid, miso.rlast});
    end
    total++;
    if (miso.rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", miso.rdata); end
    total++;
    if (miso.bresp !== OKAY || miso.rresp !== OKAY) begin
      bad++; $display("FAIL reset_resp got=%0d/%0d exp=0/0", miso.bresp, miso.rresp);
    end
    total++;
    if (miso.bid !== 8'h0 || miso.rid !== 8'h0) begin
      bad++; $display("FAIL reset_ids got=%h/%h exp=0/0", miso.bid, miso.rid);
    end
    arst = 1'b1;
  endtask

  task automatic test_single();
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF; wl[0] = 1'b1;
    do_write(32'h10, 8'h07, 8'd0, SIZE_4B, INCR);
    total++;
    if (bresp_c !== OKAY) begin bad++; $display("FAIL single_bresp got=%0d exp=0", bresp_c); end
    total++;
    if (bid_c !== 8'h07) begin bad++; $display("FAIL single_bid got=%h exp=07", bid_c); end
    do_read(32'h10, 8'h04, 8'd0, SIZE_4B, INCR, -1);
    total++;
    if (first_rv !== 1'b1) begin bad++; $display("FAIL single_rvalid_latency got=%b exp=1", first_rv); end
    total++;
    if (rd[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata got=%h exp=deadbeef", rd[0]); end
    total++;
    if (rl[0] !== 1'b1 || rr[0] !== OKAY) begin
      bad++; $display("FAIL single_rlast_rresp got=%b/%0d exp=1/0", rl[0], rr[0]);
    end
    total++;
    if (rid_c !== 8'h04) begin bad++; $display("FAIL single_rid got=%h exp=04", rid_c); end
  endtask

  task automatic test_incr_burst();
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'(i + 1); ws[i] = 4'hF; wl[i] = (i == 3);
    end
    do_write(32'h0, 8'h01, 8'd3, SIZE_4B, INCR);
    total++;
    if (bresp_c !== OKAY) begin bad++; $display("FAIL incr_bresp got=%0d exp=0", bresp_c); end
    do_read(32'h0, 8'h02, 8'd3, SIZE_4B, INCR, 1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd[i] !== 32'(i + 1) || rl[i] !== (i == 3) || rr[i] !== OKAY) begin
        bad++;
        $display("FAIL incr_beat%0d got=%h/%b/%0d exp=%h/%b/0", i, rd[i], rl[i], rr[i], i + 1, i == 3);
      end
    end
    total++;
    if (stall_d0 !== 32'h2 || stall_d1 !== 32'h2 || stall_v !== 1'b1) begin
      bad++; $display("FAIL incr_stall_hold got=%h/%h/%b exp=2/2/1", stall_d0, stall_d1, stall_v);
    end
  endtask

  task automatic test_strobes();
    wr1(32'h20, 32'h11223344, 4'hF);
    wr1(32'h20, 32'hAABBCCDD, 4'b0101);
    do_read(32'h20, '0, 8'd0, SIZE_4B, INCR, -1);
    total++;
    if (rd[0] !== 32'h11BB33DD) begin bad++; $display("FAIL strobe_merge got=%h exp=11bb33dd", rd[0]); end
  endtask

  task automatic test_errors();
    wd[0] = 32'h00000BAD; ws[0] = 4'hF; wl[0] = 1'b1;
    do_write(32'h8000, '0, 8'd0, SIZE_4B, INCR);
    total++;
    if (bresp_c !== SLVERR) begin bad++; $display("FAIL err_oor_bresp got=%0d exp=2", bresp_c); end
    do_read(32'h0, '0, 8'd0, SIZE_4B, INCR, -1);
    total++;
    if (rd[0] !== 32'h1) begin bad++; $display("FAIL err_oor_mem_unchanged got=%h exp=1", rd[0]); end
    do_read(32'h0, '0, 8'd0, SIZE_8B, INCR, -1);
    total++;
    if (rr[0] !== SLVERR || rd[0] !== 32'h0 || rl[0] !== 1'b1) begin
      bad++; $display("FAIL err_size got=%0d/%h/%b exp=2/0/1", rr[0], rd[0], rl[0]);
    end
    do_read(32'h0, '0, 8'd1, SIZE_4B, WRAP, -1);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (rr[i] !== SLVERR || rd[i] !== 32'h0 || rl[i] !== (i == 1)) begin
        bad++; $display("FAIL err_wrap_beat%0d got=%0d/%h/%b exp=2/0/%b", i, rr[i], rd[i], rl[i], i == 1);
      end
    end
    do_read(32'h7FFC, '0, 8'd1, SIZE_4B, INCR, -1);
    total++;
    if (rr[0] !== OKAY || rr[1] !== SLVERR || rd[1] !== 32'h0) begin
      bad++; $display("FAIL err_edge_perbeat got=%0d/%0d/%h exp=0/2/0", rr[0], rr[1], rd[1]);
    end
  endtask

  task automatic test_concurrency_wlast();
    wr1(32'h40, 32'h5, 4'hF);
    mosi.awvalid = 1'b1; mosi.awaddr = 32'h40; mosi.awid = '0;
    mosi.awlen = 8'd0; mosi.awsize = SIZE_4B; mosi.awburst = INCR;
    step();
    mosi.awvalid = 1'b0;
    mosi.wvalid = 1'b1; mosi.wdata = 32'h9; mosi.wstrb = 4'hF; mosi.wlast = 1'b1;
    mosi.arvalid = 1'b1; mosi.araddr = 32'h40; mosi.arid = '0;
    mosi.arlen = 8'd0; mosi.arsize = SIZE_4B; mosi.arburst = INCR;
    step();
    mosi.wvalid = 1'b0; mosi.wlast = 1'b0; mosi.arvalid = 1'b0;
    total++;
    if (miso.rvalid !== 1'b1 || miso.rdata !== 32'h5) begin
      bad++; $display("FAIL rbw_old_data got=%b/%h exp=1/5", miso.rvalid, miso.rdata);
    end
    total++;
    if (miso.bvalid !== 1'b1 || miso.bresp !== OKAY) begin
      bad++; $display("FAIL rbw_bresp got=%b/%0d exp=1/0", miso.bvalid, miso.bresp);
    end
    mosi.rready = 1'b1; mosi.bready = 1'b1;
    step();
    mosi.rready = 1'b0; mosi.bready = 1'b0;
    do_read(32'h40, '0, 8'd0, SIZE_4B, INCR, -1);
    total++;
    if (rd[0] !== 32'h9) begin bad++; $display("FAIL rbw_new_data got=%h exp=9", rd[0]); end

    wr1(32'h50, 32'h77, 4'hF);
    wd[0] = 32'h7; wd[1] = 32'h8; ws[0] = 4'hF; ws[1] = 4'hF; wl[0] = 1'b1; wl[1] = 1'b0;
    do_write(32'h50, 8'h05, 8'd1, SIZE_4B, INCR);
    total++;
    if (bresp_c !== SLVERR || bid_c !== 8'h05) begin
      bad++; $display("FAIL wlast_early_bresp got=%0d/%h exp=2/05", bresp_c, bid_c);
    end
    do_read(32'h50, '0, 8'd0, SIZE_4B, INCR, -1);
    total++;
    if (rd[0] !== 32'h77) begin bad++; $display("FAIL wlast_early_dropped got=%h exp=77", rd[0]); end
  endtask

  task automatic test_reset_mid_burst();
    mosi.arvalid = 1'b1; mosi.araddr = 32'h0; mosi.arid = 8'h03;
    mosi.arlen = 8'd7; mosi.arsize = SIZE_4B; mosi.arburst = INCR;
    step();
    mosi.arvalid = 1'b0;
    mosi.rready = 1'b1;
    step();
    step();
    total++;
    if (miso.rvalid !== 1'b1 || miso.rid !== 8'h03) begin
      bad++; $display("FAIL midrst_burst_active got=%b/%h exp=1/03", miso.rvalid, miso.rid);
    end
    #2 arst = 1'b0;
    #1;
    total++;
    if ({miso.awready, miso.arready, miso.wready, miso.bvalid, miso.rvalid, miso.rlast} !== 6'b110000) begin
      bad++;
      $display("FAIL midrst_ctrl got=%b exp=110000",
               {miso.awready, miso.arready, miso.wready, miso.bvalid, miso.rvalid, miso.rlast});
    end
    total++;
    if (miso.rdata !== 32'h0 || miso.rid !== 8'h0) begin
      bad++; $display("FAIL midrst_data_id got=%h/%h exp=0/0", miso.rdata, miso.rid);
    end
    mosi.rready = 1'b0;
    step();
    #2 arst = 1'b1;
    do_read(32'h10, 8'h09, 8'd0, SIZE_4B, INCR, -1);
    total++;
    if (first_rv !== 1'b1 || rd[0] !== 32'hDEADBEEF || rr[0] !== OKAY || rl[0] !== 1'b1 || rid_c !== 8'h09) begin
      bad++;
      $display("FAIL midrst_after_read got=%b/%h/%0d/%b/%h exp=1/deadbeef/0/1/09",
               first_rv, rd[0], rr[0], rl[0], rid_c);
    end
  endtask

  initial begin
    mosi = '0;
    arst = 1'b1;
    #1 arst = 1'b0;
    test_reset();
    test_single();
    test_incr_burst();
    test_strobes();
    test_errors();
    test_concurrency_wlast();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
